// File: rtl/adc_seq_pkg.sv
// Shared FSM encoding, default parameters and sizing helpers for the ADC conversion sequencer.
package adc_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StConvert,
    StHold
  } state_e;

  localparam int unsigned DefResultWidth   = 12;
  localparam int unsigned DefStartCycles   = 8;
  localparam int unsigned DefTimeoutCycles = 255;
  localparam int unsigned DefSyncStages    = 2;

  // Width of a saturating counter that must be able to hold max(a, b).
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return unsigned'($clog2(m + 1));
  endfunction

endpackage

// File: rtl/adc_sync_edge.sv
// Brings the asynchronous conv_done flag into the clk domain and flags its rising edges.
module adc_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q;

  // Shift the raw flag in at the bottom of the chain.
  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = async_i;
  end

  // Synchronizer chain plus the previous-value register for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/adc_conv_sequencer.sv
// Sequences one SAR conversion: start pulse, enable window, completion/timeout, result handshake.
module adc_conv_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned RESULT_WIDTH   = DefResultWidth,
  parameter int unsigned START_CYCLES   = DefStartCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
  parameter int unsigned SYNC_STAGES    = DefSyncStages
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    trig_i,
  output logic                    start_conv_o,
  output logic                    ena_out_o,
  input  logic                    conv_done_i,
  input  logic [RESULT_WIDTH-1:0] adc_data_i,
  output logic [RESULT_WIDTH-1:0] result_o,
  output logic                    result_valid_o,
  input  logic                    result_ready_i,
  output logic                    busy_o,
  output logic                    timeout_err_o,
  output logic                    overrun_err_o,
  input  logic                    err_clr_i
);

  localparam int unsigned     CntW        = cnt_width(START_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] StartLast   = CntW'(START_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [RESULT_WIDTH-1:0] result_q;
  logic                    start_conv_q, ena_q, valid_q, busy_q;
  logic                    timeout_err_q, timeout_err_d;
  logic                    overrun_err_q, overrun_err_d;
  logic                    done_rise, capture, timeout_set, overrun_set;

  adc_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .async_i(conv_done_i),
    .rise_o (done_rise)
  );

  // Next-state decode; trig outside IDLE only flags an overrun.
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    timeout_set = 1'b0;
    overrun_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trig_i) state_d = StStart;
      end
      StStart: begin
        overrun_set = trig_i;
        if (cnt_q == StartLast) state_d = StConvert;
      end
      StConvert: begin
        overrun_set = trig_i;
        // An edge on the last allowed cycle still counts as completion.
        if (done_rise) begin
          capture = 1'b1;
          state_d = StHold;
        end else if (cnt_q == TimeoutLast) begin
          timeout_set = 1'b1;
          state_d     = StIdle;
        end
      end
      StHold: begin
        overrun_set = trig_i;
        if (result_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Per-state cycle counter: restarts on every transition, saturates instead of wrapping.
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == {CntW{1'b1}}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Sticky error flags; a set on the same edge as a clear wins.
  always_comb begin
    timeout_err_d = timeout_set | (timeout_err_q & ~err_clr_i);
    overrun_err_d = overrun_set | (overrun_err_q & ~err_clr_i);
  end

  // State, counter, flags and glitch-free registered outputs decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      result_q      <= '0;
      start_conv_q  <= 1'b0;
      ena_q         <= 1'b0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      start_conv_q  <= (state_d == StStart);
      ena_q         <= (state_d == StStart) || (state_d == StConvert);
      valid_q       <= (state_d == StHold);
      busy_q        <= (state_d != StIdle);
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
      if (capture) result_q <= adc_data_i;
    end
  end

  assign start_conv_o   = start_conv_q;
  assign ena_out_o      = ena_q;
  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign busy_o         = busy_q;
  assign timeout_err_o  = timeout_err_q;
  assign overrun_err_o  = overrun_err_q;

endmodule
